// File: rtl/player_bullet_ctrl_if.sv
// ---------------------------------------------------------------------------
// player_bullet_ctrl_if
//
// Purpose: groups the player-side and judge-side signals of the player bullet
// controller into one bundle.
//
// Signals:
//   fire        - fire button level, already debounced
//   move_tick   - one-cycle frame/motion strobe
//   p_x, p_y    - player position (10-bit)
//   hit         - OR of the enemy judge hit strobes
//   b_x, b_y    - bullet position (10-bit)
//   mybullet_en - bullet alive/visible
//   ready       - a launch would be accepted this cycle
//
// Modports:
//   master - the bullet controller (consumes fire/tick/position/hit,
//            drives the bullet outputs)
//   slave  - the surrounding logic (player input, enemy judges, bench)
// ---------------------------------------------------------------------------
interface player_bullet_ctrl_if;
  logic       fire;
  logic       move_tick;
  logic [9:0] p_x;
  logic [9:0] p_y;
  logic       hit;
  logic [9:0] b_x;
  logic [9:0] b_y;
  logic       mybullet_en;
  logic       ready;

  modport master (
    input  fire, move_tick, p_x, p_y, hit,
    output b_x, b_y, mybullet_en, ready
  );

  modport slave (
    output fire, move_tick, p_x, p_y, hit,
    input  b_x, b_y, mybullet_en, ready
  );
endinterface

// File: rtl/player_bullet_ctrl.sv
// ---------------------------------------------------------------------------
// player_bullet_ctrl
//
// Purpose: launches, flies and retires the single player bullet. The bullet
// is launched from the player's muzzle, rises SPEED pixels per move_tick,
// and retires on the first enemy hit or when it would reach the top line.
// After retirement a cooldown of COOLDOWN move_ticks gates the next shot.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - player_bullet_ctrl_if.master (fire, move_tick, p_x, p_y, hit in;
//          b_x, b_y, mybullet_en, ready out)
//
// Configuration macro:
//   PLAYER_BULLET_AUTOFIRE_EN - when defined, a held fire level launches in
//   IDLE (repeat fire while held); when undefined only a fire rising edge
//   launches.
// ---------------------------------------------------------------------------
module player_bullet_ctrl #(
  parameter int SPEED    = 8,
  parameter int COOLDOWN = 4,
  parameter int TOP_Y    = 0,
  parameter int X_OFFSET = 20,
  parameter int Y_OFFSET = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  player_bullet_ctrl_if.master bus
);

  localparam int CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  // 11-bit thresholds so the comparisons cannot overflow the 10-bit range
  localparam logic [10:0] LAUNCH_MIN = 11'(Y_OFFSET + TOP_Y);
  localparam logic [10:0] RETIRE_Y   = 11'(TOP_Y + SPEED);
  localparam logic [9:0]  X_OFF      = 10'(X_OFFSET);
  localparam logic [9:0]  Y_OFF      = 10'(Y_OFFSET);
  localparam logic [9:0]  STEP       = 10'(SPEED);
  localparam logic [CNT_W-1:0] COOL_INIT = CNT_W'(COOLDOWN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             fire_q, fire_d;
  logic [9:0]       b_x_q, b_x_d;
  logic [9:0]       b_y_q, b_y_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic launch_req;
  logic launch_ok;
  logic at_top;

  assign fire_d = bus.fire;

`ifdef PLAYER_BULLET_AUTOFIRE_EN
  assign launch_req = bus.fire;
`else
  assign launch_req = bus.fire & ~fire_q;
`endif

  // Launch is refused when the muzzle would already be above the top line
  assign launch_ok = launch_req && ({1'b0, bus.p_y} >= LAUNCH_MIN);

  // One more step would reach or cross the top line, so retire instead
  assign at_top = ({1'b0, b_y_q} <= RETIRE_Y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fire_q  <= 1'b0;
      b_x_q   <= '0;
      b_y_q   <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fire_q  <= fire_d;
      b_x_q   <= b_x_d;
      b_y_q   <= b_y_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    b_x_d   = b_x_q;
    b_y_d   = b_y_q;
    en_d    = en_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (launch_ok) begin
          b_x_d   = bus.p_x + X_OFF;
          b_y_d   = bus.p_y - Y_OFF;
          en_d    = 1'b1;
          state_d = FLY;
        end
      end

      FLY: begin
        // Hit has priority over motion; the position freezes where it was
        if (bus.hit || (bus.move_tick && at_top)) begin
          en_d    = 1'b0;
          cnt_d   = COOL_INIT;
          state_d = COOL;
        end else if (bus.move_tick) begin
          b_y_d = b_y_q - STEP;
        end
      end

      COOL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else if (bus.move_tick) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  assign bus.b_x         = b_x_q;
  assign bus.b_y         = b_y_q;
  assign bus.mybullet_en = en_q;
  assign bus.ready       = (state_q == IDLE);

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// ---------------------------------------------------------------------------
// tb_player_bullet_ctrl
//
// Self-checking bench for player_bullet_ctrl: directed scenarios followed by
// a randomized run against a behavioural model of the bullet's life cycle.
// ---------------------------------------------------------------------------
module tb_player_bullet_ctrl;

  localparam int SPEED    = 8;
  localparam int COOLDOWN = 4;
  localparam int TOP_Y    = 0;
  localparam int X_OFFSET = 20;
  localparam int Y_OFFSET = 10;

  logic clk;
  logic rst;

  player_bullet_ctrl_if bus ();

  player_bullet_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors;
  int miscompares;

  // Behavioural model: is the bullet alive, where is it, is a shot allowed,
  // and how many ticks of waiting remain once it has gone.
  logic [9:0] m_bx;
  logic [9:0] m_by;
  logic       m_alive;
  logic       m_ready;
  int         m_left;
  logic       m_fire_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: drive at the falling edge, sample 1 after the rising edge
  task automatic cyc(input logic f, input logic t, input logic h);
    @(negedge clk);
    bus.fire      = f;
    bus.move_tick = t;
    bus.hit       = h;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.fire      = 1'b0;
    bus.move_tick = 1'b0;
    bus.hit       = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Four cooldown ticks then the cycle that returns to idle
  task automatic finish_cool();
    for (int i = 0; i < COOLDOWN; i++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (bus.mybullet_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_en: got %b expected 0", bus.mybullet_en); end
    vectors++; if (bus.b_x !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_bx: got %0d expected 0", bus.b_x); end
    vectors++; if (bus.b_y !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_by: got %0d expected 0", bus.b_y); end
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.ready); end
  endtask

  task automatic test_launch();
    bus.p_x = 10'd100;
    bus.p_y = 10'd400;
    cyc(1'b1, 1'b0, 1'b0);
    vectors++; if (bus.mybullet_en !== 1'b1) begin miscompares++; $display("[TB] FAIL launch_en: got %b expected 1", bus.mybullet_en); end
    vectors++; if (bus.b_x !== 10'd120) begin miscompares++; $display("[TB] FAIL launch_bx: got %0d expected 120", bus.b_x); end
    vectors++; if (bus.b_y !== 10'd390) begin miscompares++; $display("[TB] FAIL launch_by: got %0d expected 390", bus.b_y); end
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL launch_ready: got %b expected 0", bus.ready); end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flight();
    int steps;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0);
    vectors++; if (bus.b_y !== 10'd310) begin miscompares++; $display("[TB] FAIL flight_by10: got %0d expected 310", bus.b_y); end
    steps = 0;
    while (bus.mybullet_en === 1'b1 && steps < 100) begin
      cyc(1'b0, 1'b1, 1'b0);
      steps++;
    end
    // 38 ticks take 310 down to 6, the 39th retires
    vectors++; if (steps != 39) begin miscompares++; $display("[TB] FAIL flight_ticks: got %0d expected 39", steps); end
    vectors++; if (bus.mybullet_en !== 1'b0) begin miscompares++; $display("[TB] FAIL flight_retire_en: got %b expected 0", bus.mybullet_en); end
    vectors++; if (bus.b_y !== 10'd6) begin miscompares++; $display("[TB] FAIL flight_retire_by: got %0d expected 6", bus.b_y); end
    // hit during cooldown is ignored
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 1; i < COOLDOWN; i++) cyc(1'b0, 1'b1, 1'b0);
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL cool_ready_early: got %b expected 0", bus.ready); end
    cyc(1'b0, 1'b0, 1'b0);
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL cool_ready: got %b expected 1", bus.ready); end
    vectors++; if (bus.b_y !== 10'd6) begin miscompares++; $display("[TB] FAIL cool_by_frozen: got %0d expected 6", bus.b_y); end
  endtask

  task automatic test_hit_and_tick();
    bus.p_x = 10'd30;
    bus.p_y = 10'd210;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    vectors++; if (bus.b_y !== 10'd200) begin miscompares++; $display("[TB] FAIL hit_setup_by: got %0d expected 200", bus.b_y); end
    cyc(1'b0, 1'b1, 1'b1);
    vectors++; if (bus.mybullet_en !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_en: got %b expected 0", bus.mybullet_en); end
    vectors++; if (bus.b_y !== 10'd200) begin miscompares++; $display("[TB] FAIL hit_by: got %0d expected 200", bus.b_y); end
    vectors++; if (bus.b_x !== 10'd50) begin miscompares++; $display("[TB] FAIL hit_bx: got %0d expected 50", bus.b_x); end
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hit_ready: got %b expected 0", bus.ready); end
    finish_cool();
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL hit_cool_done: got %b expected 1", bus.ready); end
  endtask

  task automatic test_fire_discard();
    bus.p_x = 10'd300;
    bus.p_y = 10'd500;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    bus.p_x = 10'd50;
    bus.p_y = 10'd700;
    cyc(1'b1, 1'b0, 1'b0);
    vectors++; if (bus.b_x !== 10'd320) begin miscompares++; $display("[TB] FAIL fly_press_bx: got %0d expected 320", bus.b_x); end
    vectors++; if (bus.b_y !== 10'd490) begin miscompares++; $display("[TB] FAIL fly_press_by: got %0d expected 490", bus.b_y); end
    cyc(1'b0, 1'b1, 1'b0);
    vectors++; if (bus.b_y !== 10'd482) begin miscompares++; $display("[TB] FAIL fly_tick_by: got %0d expected 482", bus.b_y); end
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    vectors++; if (bus.mybullet_en !== 1'b0) begin miscompares++; $display("[TB] FAIL cool_press_en: got %b expected 0", bus.mybullet_en); end
    vectors++; if (bus.b_y !== 10'd482) begin miscompares++; $display("[TB] FAIL cool_press_by: got %0d expected 482", bus.b_y); end
    vectors++; if (bus.b_x !== 10'd320) begin miscompares++; $display("[TB] FAIL cool_press_bx: got %0d expected 320", bus.b_x); end
    finish_cool();
    cyc(1'b1, 1'b0, 1'b0);
    vectors++; if (bus.mybullet_en !== 1'b1) begin miscompares++; $display("[TB] FAIL relaunch_en: got %b expected 1", bus.mybullet_en); end
    vectors++; if (bus.b_x !== 10'd70) begin miscompares++; $display("[TB] FAIL relaunch_bx: got %0d expected 70", bus.b_x); end
    vectors++; if (bus.b_y !== 10'd690) begin miscompares++; $display("[TB] FAIL relaunch_by: got %0d expected 690", bus.b_y); end
    cyc(1'b0, 1'b0, 1'b1);
    finish_cool();
  endtask

  task automatic test_boundary();
    // muzzle above the top line: refused
    bus.p_x = 10'd1010;
    bus.p_y = 10'd9;
    cyc(1'b1, 1'b0, 1'b0);
    vectors++; if (bus.mybullet_en !== 1'b0) begin miscompares++; $display("[TB] FAIL refuse_en: got %b expected 0", bus.mybullet_en); end
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL refuse_ready: got %b expected 1", bus.ready); end
    cyc(1'b0, 1'b0, 1'b0);
    // exactly on the line: accepted, x wraps to 6
    bus.p_y = 10'd10;
    cyc(1'b1, 1'b0, 1'b0);
    vectors++; if (bus.mybullet_en !== 1'b1) begin miscompares++; $display("[TB] FAIL edge_launch_en: got %b expected 1", bus.mybullet_en); end
    vectors++; if (bus.b_x !== 10'd6) begin miscompares++; $display("[TB] FAIL edge_launch_bx: got %0d expected 6", bus.b_x); end
    vectors++; if (bus.b_y !== 10'd0) begin miscompares++; $display("[TB] FAIL edge_launch_by: got %0d expected 0", bus.b_y); end
    cyc(1'b0, 1'b1, 1'b0);
    vectors++; if (bus.mybullet_en !== 1'b0) begin miscompares++; $display("[TB] FAIL edge_retire_en: got %b expected 0", bus.mybullet_en); end
    vectors++; if (bus.b_y !== 10'd0) begin miscompares++; $display("[TB] FAIL edge_retire_by: got %0d expected 0", bus.b_y); end
    finish_cool();
  endtask

  task automatic test_async_reset();
    bus.p_x = 10'd200;
    bus.p_y = 10'd400;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    vectors++; if (bus.mybullet_en !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_pre_en: got %b expected 1", bus.mybullet_en); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (bus.mybullet_en !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_en: got %b expected 0", bus.mybullet_en); end
    vectors++; if (bus.b_x !== 10'd0) begin miscompares++; $display("[TB] FAIL areset_bx: got %0d expected 0", bus.b_x); end
    vectors++; if (bus.b_y !== 10'd0) begin miscompares++; $display("[TB] FAIL areset_by: got %0d expected 0", bus.b_y); end
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_ready: got %b expected 1", bus.ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fire_held();
    int steps;
    bus.p_x = 10'd0;
    bus.p_y = 10'd40;
    cyc(1'b1, 1'b0, 1'b0);
    vectors++; if (bus.b_y !== 10'd30) begin miscompares++; $display("[TB] FAIL held_launch_by: got %0d expected 30", bus.b_y); end
    steps = 0;
    while (bus.mybullet_en === 1'b1 && steps < 20) begin
      cyc(1'b1, 1'b1, 1'b0);
      steps++;
    end
    vectors++; if (steps != 4) begin miscompares++; $display("[TB] FAIL held_flight_ticks: got %0d expected 4", steps); end
    for (int i = 0; i < COOLDOWN; i++) cyc(1'b1, 1'b1, 1'b0);
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("[TB] FAIL held_cool_ready: got %b expected 0", bus.ready); end
    cyc(1'b1, 1'b0, 1'b0);
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL held_ready_rise: got %b expected 1", bus.ready); end
    cyc(1'b1, 1'b0, 1'b0);
`ifdef PLAYER_BULLET_AUTOFIRE_EN
    vectors++; if (bus.mybullet_en !== 1'b1) begin miscompares++; $display("[TB] FAIL held_second_en: got %b expected 1", bus.mybullet_en); end
    vectors++; if (bus.b_y !== 10'd30) begin miscompares++; $display("[TB] FAIL held_second_by: got %0d expected 30", bus.b_y); end
    cyc(1'b0, 1'b0, 1'b1);
    finish_cool();
`else
    vectors++; if (bus.mybullet_en !== 1'b0) begin miscompares++; $display("[TB] FAIL held_single_en: got %b expected 0", bus.mybullet_en); end
    vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("[TB] FAIL held_single_ready: got %b expected 1", bus.ready); end
`endif
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic launch;
    do_reset();
    m_bx        = 10'd0;
    m_by        = 10'd0;
    m_alive     = 1'b0;
    m_ready     = 1'b1;
    m_left      = 0;
    m_fire_prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      vectors++; if (bus.mybullet_en !== m_alive) begin miscompares++; $display("[TB] FAIL rand_en @%0d: got %b expected %b", i, bus.mybullet_en, m_alive); end
      vectors++; if (bus.ready !== m_ready) begin miscompares++; $display("[TB] FAIL rand_ready @%0d: got %b expected %b", i, bus.ready, m_ready); end
      vectors++; if (bus.b_x !== m_bx) begin miscompares++; $display("[TB] FAIL rand_bx @%0d: got %0d expected %0d", i, bus.b_x, m_bx); end
      vectors++; if (bus.b_y !== m_by) begin miscompares++; $display("[TB] FAIL rand_by @%0d: got %0d expected %0d", i, bus.b_y, m_by); end

      if ($urandom_range(0, 3) == 0) bus.fire = ~bus.fire;
      bus.move_tick = ($urandom_range(0, 3) == 0);
      bus.hit       = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) begin
        bus.p_x = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) == 0) bus.p_y = 10'($urandom_range(0, 20));
        else                           bus.p_y = 10'($urandom_range(0, 1023));
      end

`ifdef PLAYER_BULLET_AUTOFIRE_EN
      launch = bus.fire;
`else
      launch = bus.fire && !m_fire_prev;
`endif
      if (m_ready) begin
        if (launch && int'(bus.p_y) >= Y_OFFSET + TOP_Y) begin
          m_alive = 1'b1;
          m_ready = 1'b0;
          m_bx    = 10'((int'(bus.p_x) + X_OFFSET) % 1024);
          m_by    = 10'(int'(bus.p_y) - Y_OFFSET);
        end
      end else if (m_alive) begin
        if (bus.hit || (bus.move_tick && int'(m_by) <= TOP_Y + SPEED)) begin
          m_alive = 1'b0;
          m_left  = COOLDOWN;
        end else if (bus.move_tick) begin
          m_by = 10'(int'(m_by) - SPEED);
        end
      end else begin
        if (m_left == 0) m_ready = 1'b1;
        else if (bus.move_tick) m_left--;
      end
      m_fire_prev = bus.fire;
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.fire      = 1'b0;
    bus.move_tick = 1'b0;
    bus.hit       = 1'b0;
    bus.p_x       = 10'd0;
    bus.p_y       = 10'd0;
    $display("[TB] start");
    test_reset();
    test_launch();
    test_flight();
    test_hit_and_tick();
    test_fire_discard();
    test_boundary();
    test_async_reset();
    test_fire_held();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
